oam_dma_controller: RTL and testbench
=====================================

Name: oam_dma_controller

Overview:
- Implements the NES sprite DMA register at $4014.
- A CPU write of page P halts the CPU, takes over the shared CPU memory bus, and copies 256 bytes from $P00-$PFF into the PPU OAM data port at $2004.
- Sits between the 6502 core and the CPU-side memory/IO decode. An external bus mux selects DMA-driven bus signals whenever bus_grant is high.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cpu_ce  in  1  one-clk pulse marking the last clk of each CPU cycle; at least 2 clks apart.
- cpu_addr  in  16  CPU address bus.
- cpu_wr  in  1  CPU write strobe.
- cpu_wdata  in  8  CPU write data.
- bus_rdata  in  8  read data returned from the shared bus; 1-clk synchronous memory latency.
- cpu_rdy  out  1  0 halts the CPU.
- bus_grant  out  1  1 selects DMA bus signals.
- dma_cs_n  out  1  active-low bus chip select.
- dma_rd  out  1  DMA read strobe.
- dma_wr  out  1  DMA write strobe.
- dma_addr  out  16  DMA address.
- dma_wdata  out  8  DMA write data.
- dma_active  out  1  high from trigger acceptance until completion.
- dma_done  out  1  one-clk pulse when the 256th write completes.

Behaviour:
- Reset values:
  - State IDLE.
  - cpu_rdy=1, bus_grant=0, dma_cs_n=1, dma_rd=0, dma_wr=0, dma_addr=0, dma_wdata=0.
  - dma_active=0, dma_done=0.
  - page=0, idx=0, parity=0.
- State changes and cycle-level actions occur only on clks where cpu_ce=1. The exception is rst, which acts on any clk.
- parity:
  - Toggles on every cpu_ce, including while IDLE.
  - parity=0 marks a "get" (read) cycle; parity=1 marks a "put" (write) cycle.
- Trigger:
  - Condition: IDLE, cpu_ce=1, cpu_wr=1, cpu_addr==DMA_REG_ADDR.
  - Action: page<=cpu_wdata, idx<=0, state<=HALT, cpu_rdy<=0, dma_active<=1.
  - Writes to DMA_REG_ADDR outside IDLE are ignored.
- HALT:
  - One CPU cycle, bus not yet granted.
  - At its cpu_ce: next state is READ if the upcoming cycle is a get (parity after toggle = 0), else ALIGN.
- ALIGN:
  - One idle CPU cycle, bus_grant=1, no strobes.
  - Next state: READ.
- READ:
  - Outputs: bus_grant=1, dma_cs_n=0, dma_rd=1, dma_wr=0, dma_addr={page,idx}.
  - At the cpu_ce ending the cycle: dma_wdata<=bus_rdata, state<=WRITE.
- WRITE:
  - Outputs: bus_grant=1, dma_cs_n=0, dma_rd=0, dma_wr=1, dma_addr=OAM_DATA_ADDR, dma_wdata holds the captured byte.
  - At its cpu_ce, if idx!=255: idx<=idx+1, state<=READ.
  - At its cpu_ce, if idx==255: state<=IDLE, dma_done<=1 for one clk, cpu_rdy<=1, bus_grant<=0, dma_active<=0, all strobes deasserted.
- idx is 8-bit with no wrap past 255; termination is at 255.
- Total halt length counts CPU cycles from the trigger cycle's end until cpu_rdy returns: 513 (HALT + 512) when no alignment is needed, 514 with ALIGN.
- cpu_rdy drops at the clk after the trigger cpu_ce.
- rst mid-transfer: immediate return to reset values next clk. No further bus strobes, and no dma_done.
- Simultaneous trigger and rst: rst wins.
- cpu_ce held low freezes all state and outputs.

Test Plan:
- Trigger on a parity-0 cycle: write $4014=$02 with RAM $0200-$02FF = i^$5A, cpu_ce every 3 clks. Required:
  - 513 CPU cycles with cpu_rdy=0.
  - 256 writes to $2004 with data i^$5A in order.
  - Single dma_done pulse.
- Same transfer triggered on a parity-1 cycle: exactly one ALIGN cycle, 514 halted cycles, identical write stream.
- Address checks:
  - dma_addr sequence alternates $0200,$2004,$0201,...,$02FF,$2004.
  - dma_cs_n=0 only in READ/WRITE.
  - No dma_rd and dma_wr high together.
- Reset mid-transfer: assert rst after idx=100 write. Required:
  - Next clk cpu_rdy=1, bus_grant=0, strobes 0.
  - No dma_done.
  - A fresh $4014=$03 write restarts at $0300.
- Ignored writes:
  - $4014 written with cpu_ce=0, or $4015 written, causes no DMA.
  - A second $4014 write during an active DMA leaves page unchanged; the transfer completes normally.
- Back-to-back: a trigger in the first CPU cycle after dma_done starts a new DMA with correct 513/514 length.

Source files
------------

// File: rtl/oam_dma_if.sv
// oam_dma_if: CPU-side bus and DMA bus-master signals of the sprite DMA controller
interface oam_dma_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy;
  logic        bus_grant;
  logic        dma_cs_n;
  logic        dma_rd;
  logic        dma_wr;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_active;
  logic        dma_done;
  modport master (
    input  cpu_ce, cpu_addr, cpu_wr, cpu_wdata, bus_rdata,
    output cpu_rdy, bus_grant, dma_cs_n, dma_rd, dma_wr, dma_addr, dma_wdata, dma_active, dma_done
  );
  modport slave (
    output cpu_ce, cpu_addr, cpu_wr, cpu_wdata, bus_rdata,
    input  cpu_rdy, bus_grant, dma_cs_n, dma_rd, dma_wr, dma_addr, dma_wdata, dma_active, dma_done
  );
endinterface

// File: rtl/oam_dma_controller.sv
// oam_dma_controller: NES $4014 sprite DMA, copies page P to the OAM data port while halting the CPU
module oam_dma_controller #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic        clk,
  input logic        rst,
  oam_dma_if.master  bus
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state, state_nx;
  logic [7:0] page, idx, wdata;
  logic parity, done, trig, last;
  assign trig = state == IDLE && bus.cpu_ce && bus.cpu_wr && bus.cpu_addr == DMA_REG_ADDR;
  assign last = state == WRITE && idx == 8'hff;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // parity is the pre-toggle value; HALT enters READ only if the next cycle is a get
  always_comb begin
    state_nx = state;
    if (bus.cpu_ce)
      case (state)
        IDLE:    state_nx = trig ? HALT : IDLE;
        HALT:    state_nx = parity ? READ : ALIGN;
        ALIGN:   state_nx = READ;
        READ:    state_nx = WRITE;
        WRITE:   state_nx = last ? IDLE : READ;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      page   <= '0;
      idx    <= '0;
      wdata  <= '0;
      parity <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.cpu_ce) begin
        parity <= ~parity;
        done   <= last;
        if (trig) begin
          page <= bus.cpu_wdata;
          idx  <= '0;
        end
        if (state == READ) wdata <= bus.bus_rdata;
        if (state == WRITE && !last) idx <= idx + 8'd1;
      end
    end
  assign bus.cpu_rdy    = state == IDLE;
  assign bus.dma_active = state != IDLE;
  assign bus.bus_grant  = state == ALIGN || state == READ || state == WRITE;
  assign bus.dma_rd     = state == READ;
  assign bus.dma_wr     = state == WRITE;
  assign bus.dma_cs_n   = !(state == READ || state == WRITE);
  assign bus.dma_addr   = state == READ ? {page, idx} : state == WRITE ? OAM_DATA_ADDR : 16'h0000;
  assign bus.dma_wdata  = wdata;
  assign bus.dma_done   = done;
endmodule

// File: tb/tb_oam_dma_controller.sv
// tb_oam_dma_controller: randomized CPU-cycle stimulus checked against a transfer-level model
module tb_oam_dma_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  oam_dma_if bus();
  oam_dma_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [7:0] ram [65536];
  always_ff @(posedge clk) bus.bus_rdata <= ram[bus.dma_addr];

  int n_cmp = 0;
  int n_bad = 0;
  bit model_par = 1'b0;

  logic [7:0]  wq[$];
  logic [15:0] rq[$];
  int halt_cnt, align_cnt, done_cnt, viol;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.dma_done) done_cnt++;
    if (bus.dma_rd && bus.dma_wr) viol++;
    if (bus.dma_cs_n !== !(bus.dma_rd || bus.dma_wr)) viol++;
    if (bus.cpu_ce) begin
      if (!bus.cpu_rdy) halt_cnt++;
      if (!bus.cpu_rdy && bus.bus_grant && !bus.dma_rd && !bus.dma_wr) align_cnt++;
      if (bus.dma_rd) rq.push_back(bus.dma_addr);
      if (bus.dma_wr) begin
        wq.push_back(bus.dma_wdata);
        if (bus.dma_addr !== 16'h2004) viol++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq.delete();
    rq.delete();
    halt_cnt = 0;
    align_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input bit w, input logic [7:0] d, input bit ce_on);
    int gap = $urandom_range(2, 4);
    bus.cpu_addr = a;
    bus.cpu_wr = w;
    bus.cpu_wdata = d;
    bus.cpu_ce = 1'b0;
    repeat (gap - 1) tick();
    bus.cpu_ce = ce_on;
    tick();
    bus.cpu_ce = 1'b0;
    bus.cpu_wr = 1'b0;
    if (ce_on) model_par = ~model_par;
  endtask

  task automatic idle_cycle();
    logic [15:0] a = 16'($urandom);
    cpu_cycle(a, 1'b0, 8'($urandom), 1'b1);
  endtask

  task automatic check_stream(input logic [7:0] pg, input int n);
    int bad_w = 0;
    int bad_r = 0;
    for (int i = 0; i < n && i < wq.size(); i++)
      if (wq[i] !== ram[{pg, 8'(i)}]) bad_w++;
    for (int i = 0; i < n && i < rq.size(); i++)
      if (rq[i] !== {pg, 8'(i)}) bad_r++;
    chk("write_data_errs", bad_w, 0);
    chk("read_addr_errs", bad_r, 0);
  endtask

  task automatic run_dma(input logic [7:0] pg, input int want_par, input bit inject);
    bit trig_par;
    bit seen = 1'b0;
    while (want_par >= 0 && model_par != want_par[0]) idle_cycle();
    clear_mon();
    trig_par = model_par;
    cpu_cycle(16'h4014, 1'b1, pg, 1'b1);
    chk("rdy_drop", bus.cpu_rdy, 1'b0);
    for (int k = 0; k < 700 && !seen; k++) begin
      if (inject && k == 40) cpu_cycle(16'h4014, 1'b1, ~pg, 1'b1);
      else idle_cycle();
      seen = bus.dma_done;
    end
    tick();
    chk("done_seen", seen, 1'b1);
    chk("done_pulses", done_cnt, 1);
    chk("halt_len", halt_cnt, 513 + trig_par);
    chk("align_cycles", align_cnt, trig_par);
    chk("write_count", wq.size(), 256);
    chk("read_count", rq.size(), 256);
    check_stream(pg, 256);
    chk("rdy_back", bus.cpu_rdy, 1'b1);
    chk("active_off", bus.dma_active, 1'b0);
  endtask

  initial begin
    bool_init: begin end
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) ram[16'h0200 + i] = 8'(i) ^ 8'h5a;
    bus.cpu_ce = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wr = 1'b0;
    bus.cpu_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    model_par = 1'b0;
    chk("rst_cpu_rdy", bus.cpu_rdy, 1'b1);
    chk("rst_grant", bus.bus_grant, 1'b0);
    chk("rst_cs_n", bus.dma_cs_n, 1'b1);
    chk("rst_rd", bus.dma_rd, 1'b0);
    chk("rst_wr", bus.dma_wr, 1'b0);
    chk("rst_addr", bus.dma_addr, 16'h0000);
    chk("rst_wdata", bus.dma_wdata, 8'h00);
    chk("rst_active", bus.dma_active, 1'b0);
    chk("rst_done", bus.dma_done, 1'b0);

    run_dma(8'h02, 0, 1'b0);
    run_dma(8'h02, 1, 1'b0);
    run_dma(8'($urandom_range(0, 7)), -1, 1'b0);
    run_dma(8'($urandom_range(8, 15)), -1, 1'b1);

    // abort after the idx=100 write
    clear_mon();
    cpu_cycle(16'h4014, 1'b1, 8'h02, 1'b1);
    for (int k = 0; k < 400 && wq.size() < 101; k++) idle_cycle();
    chk("abort_reached", wq.size(), 101);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_par = 1'b0;
    chk("abort_rdy", bus.cpu_rdy, 1'b1);
    chk("abort_grant", bus.bus_grant, 1'b0);
    chk("abort_rd", bus.dma_rd, 1'b0);
    chk("abort_wr", bus.dma_wr, 1'b0);
    chk("abort_cs_n", bus.dma_cs_n, 1'b1);
    chk("abort_active", bus.dma_active, 1'b0);
    done_cnt = 0;
    halt_cnt = 0;
    repeat (6) idle_cycle();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_halt", halt_cnt, 0);
    run_dma(8'h03, -1, 1'b0);

    clear_mon();
    cpu_cycle(16'h4014, 1'b1, 8'h05, 1'b0);
    cpu_cycle(16'h4015, 1'b1, 8'h05, 1'b1);
    repeat (4) idle_cycle();
    chk("ignored_rdy", bus.cpu_rdy, 1'b1);
    chk("ignored_active", bus.dma_active, 1'b0);
    chk("ignored_halt", halt_cnt, 0);
    chk("ignored_reads", rq.size(), 0);
    run_dma(8'h06, -1, 1'b0);

    chk("bus_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
